tag_compare: RTL and testbench
==============================

# tag_compare

Cache tag comparator for the L1 data cache. It compares the tag of an incoming request address against the tag stored for the indexed cache line and reports a hit when the tags match and the line is valid. The match/hit result is available combinationally for the cache's read/write hit logic and as a registered, valid-qualified copy for pipelined consumers. The read path and the write path each instantiate one copy.

## Interface
- TAG_W, default 2: request tag width (address bits [16:15]).
- STORED_W, default 3: stored tag field width; must be ≥ TAG_W.
- clk  input  1: single clock; all state updates on its rising edge.
- reset  input  1: synchronous, active-high reset.
- cmp_valid  input  1: a comparison is presented this cycle.
- req_tag  input  TAG_W: tag of the request address.
- stored_tag  input  STORED_W: tag held for the indexed line.
- line_valid  input  1: validity bit of the indexed line.
- match  output  1: combinational tag equality.
- hit  output  1: combinational, match AND line_valid.
- out_valid  output  1: registered; a registered result is present.
- hit_q  output  1: registered hit for the comparison flagged by out_valid.
- hit_count  output  16: hit counter, used only with the stats feature.
- miss_count  output  16: miss counter, used only with the stats feature.

## Operation
- Compare req_tag zero-extended to STORED_W with the full stored_tag; match=1 only when every bit is equal.
- Any 1 in stored_tag[STORED_W-1:TAG_W] forces match=0.
- hit = match & line_valid. A matching tag on an invalid line is a miss.
- match and hit do not depend on cmp_valid or reset; they are pure functions of the current inputs.
- Registered path, on each clock edge:
  - out_valid ← cmp_valid.
  - hit_q ← hit when cmp_valid=1; otherwise hit_q holds its value.
- A qualified comparison is a cycle with cmp_valid=1. With stats enabled, every qualified comparison increments exactly one counter: hit_count on hit=1, miss_count on hit=0.
- Counters saturate at 16'hFFFF and do not wrap.

## Timing
- match and hit: zero-cycle combinational latency.
- hit_q and out_valid: one cycle of latency. Comparison presented in cycle N appears in cycle N+1.
- Back-to-back cmp_valid is fully pipelined at one result per cycle. There is no backpressure and no stall.
- Reset values: out_valid=0, hit_q=0, hit_count=0, miss_count=0. Combinational outputs follow the inputs during reset.
- Reset has priority over cmp_valid in the same cycle: registers clear and that comparison is not counted.
- Reset mid-stream drops any in-flight registered result. The first post-reset out_valid comes one cycle after the first post-reset cmp_valid.
- Counter saturation: a qualified comparison at FFFF leaves that counter at FFFF. The other counter still increments normally.

## Configuration
- TAG_COMPARE_STATS_EN defined:
  - hit_count and miss_count are implemented as described above.
- TAG_COMPARE_STATS_EN undefined:
  - No counter flops are built.
  - hit_count and miss_count are tied to 16'h0000.
  - All other behaviour is identical.

## Test plan
- Reset, then req_tag=2'b10, stored_tag=3'b010, line_valid=1, cmp_valid=1 → match=1 and hit=1 in the same cycle; next cycle out_valid=1, hit_q=1, hit_count=1.
- req_tag=2'b10, stored_tag=3'b010, line_valid=0, cmp_valid=1 → match=1, hit=0; next cycle hit_q=0, miss_count increments by 1.
- req_tag=2'b10, stored_tag=3'b110, line_valid=1 → match=0, hit=0 (upper stored bit set).
- Four back-to-back cmp_valid cycles with hits H,M,H,H → hit_q sequence 1,0,1,1 one cycle delayed, out_valid high for 4 cycles; hit_count=3, miss_count=1.
- reset asserted in the same cycle as cmp_valid=1 with a hit → next cycle out_valid=0, hit_q=0, counters 0.
- Stats enabled, hit_count preloaded to FFFF by 65535 hits, then one more hit → hit_count stays FFFF. Without the macro, both counters read 0 throughout.

Source files
------------

// File: rtl/tag_compare.sv
// tag_compare: L1 data cache tag comparator.
// Produces a combinational match/hit for the cache hit logic, and a
// registered, valid-qualified hit (out_valid/hit_q) one cycle later.
// Optional hit/miss statistics counters are built only when the macro
// TAG_COMPARE_STATS_EN is defined; otherwise both counters read zero.
module tag_compare #(
    parameter int TAG_W    = 2,
    parameter int STORED_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmp_valid,
    input  logic [TAG_W-1:0]    req_tag,
    input  logic [STORED_W-1:0] stored_tag,
    input  logic                line_valid,
    output logic                match,
    output logic                hit,
    output logic                out_valid,
    output logic                hit_q,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count
);

    // Per-bit equality of the zero-extended request tag against the stored
    // tag. Bits above TAG_W compare against an implicit zero, so any 1 in
    // the upper stored field kills the match.
    logic [STORED_W-1:0] bitEq;

    generate
        for (genvar gi = 0; gi < STORED_W; gi++) begin : gBitEq
            if (gi < TAG_W) begin : gReqBit
                assign bitEq[gi] = (req_tag[gi] == stored_tag[gi]);
            end else begin : gPadBit
                assign bitEq[gi] = ~stored_tag[gi];
            end
        end
    endgenerate

    assign match = &bitEq;
    assign hit   = match & line_valid;

    // Registered result path: valid follows cmp_valid, hit_q only updates
    // on a qualified comparison so it holds the last result otherwise.
    logic outValidReg, outValidNext;
    logic hitQReg, hitQNext;

    // Next-state for the registered result.
    always_comb begin
        outValidNext = cmp_valid;
        hitQNext     = hitQReg;
        if (cmp_valid) begin
            hitQNext = hit;
        end
    end

    // Result registers; reset wins over a same-cycle comparison.
    always_ff @(posedge clk) begin
        if (reset) begin
            outValidReg <= 1'b0;
            hitQReg     <= 1'b0;
        end else begin
            outValidReg <= outValidNext;
            hitQReg     <= hitQNext;
        end
    end

    assign out_valid = outValidReg;
    assign hit_q     = hitQReg;

`ifdef TAG_COMPARE_STATS_EN
    // Saturating hit/miss counters; each qualified comparison bumps exactly one.
    logic [15:0] hitCountReg, hitCountNext;
    logic [15:0] missCountReg, missCountNext;

    // Counter next-state with saturation at all-ones.
    always_comb begin
        hitCountNext  = hitCountReg;
        missCountNext = missCountReg;
        if (cmp_valid) begin
            if (hit) begin
                if (hitCountReg != 16'hFFFF) begin
                    hitCountNext = hitCountReg + 16'd1;
                end
            end else begin
                if (missCountReg != 16'hFFFF) begin
                    missCountNext = missCountReg + 16'd1;
                end
            end
        end
    end

    // Counter registers; a comparison in a reset cycle is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            hitCountReg  <= 16'h0000;
            missCountReg <= 16'h0000;
        end else begin
            hitCountReg  <= hitCountNext;
            missCountReg <= missCountNext;
        end
    end

    assign hit_count  = hitCountReg;
    assign miss_count = missCountReg;
`else
    assign hit_count  = 16'h0000;
    assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_tag_compare.sv
// tb_tag_compare: scoreboard bench for tag_compare.
// A reference process pushes the expected registered hit at each clock edge;
// a monitor on the falling edge pops and compares whenever out_valid is due.
// Counter expectations follow TAG_COMPARE_STATS_EN (zero when undefined).
module tb_tag_compare;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmp_valid = 1'b0;
    logic [1:0]  req_tag = '0;
    logic [2:0]  stored_tag = '0;
    logic        line_valid = 1'b0;
    logic        match, hit, out_valid, hit_q;
    logic [15:0] hit_count, miss_count;

    always #5 clk = ~clk;

    tag_compare #(.TAG_W(2), .STORED_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmp_valid  (cmp_valid),
        .req_tag    (req_tag),
        .stored_tag (stored_tag),
        .line_valid (line_valid),
        .match      (match),
        .hit        (hit),
        .out_valid  (out_valid),
        .hit_q      (hit_q),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int passCount  = 0;
    int checkCount = 0;
    bit quiet      = 1'b0;
    bit started    = 1'b0;

    function automatic void check(string name, int actual, int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endfunction

    // Reference: tags match when the stored value equals the request value
    // as plain integers (upper stored bits must therefore be zero).
    function automatic bit refMatch(logic [1:0] rt, logic [2:0] st);
        return int'(st) == int'(rt);
    endfunction

    // Scoreboard state.
    bit          expQ[$];
    bit          lastHit = 1'b0;
    int unsigned expHits = 0;
    int unsigned expMisses = 0;

    // Reference model: observe inputs at each rising edge.
    always @(posedge clk) begin
        bit h;
        if (reset) begin
            expQ.delete();
            lastHit   = 1'b0;
            expHits   = 0;
            expMisses = 0;
        end else if (cmp_valid) begin
            h = refMatch(req_tag, stored_tag) && line_valid;
            expQ.push_back(h);
            lastHit = h;
`ifdef TAG_COMPARE_STATS_EN
            if (h) begin
                if (expHits < 65535) expHits++;
            end else begin
                if (expMisses < 65535) expMisses++;
            end
`endif
        end
    end

    // Monitor: compare registered outputs away from the active edge.
    always @(negedge clk) begin
        bit e;
        if (started) begin
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("out_valid", int'(out_valid), 1);
                check("hit_q", int'(hit_q), int'(e));
                if (!quiet)
                    $display("txn hit_q=%0d exp=%0d hit_count=%0d miss_count=%0d",
                             hit_q, e, hit_count, miss_count);
            end else begin
                check("out_valid_idle", int'(out_valid), 0);
                check("hit_q_hold", int'(hit_q), int'(lastHit));
            end
            check("hit_count", int'(hit_count), int'(expHits));
            check("miss_count", int'(miss_count), int'(expMisses));
        end
    end

    // Drive one cycle of stimulus and check the combinational outputs.
    task automatic drive(input bit cv, input logic [1:0] rt, input logic [2:0] st,
                         input bit lv, input bit rst);
        bit m;
        @(posedge clk);
        #1;
        cmp_valid  = cv;
        req_tag    = rt;
        stored_tag = st;
        line_valid = lv;
        reset      = rst;
        #1;
        m = refMatch(rt, st);
        check("match", int'(match), int'(m));
        check("hit", int'(hit), int'(m && lv));
    endtask

    initial begin
        // Reset for two cycles; monitor starts once registers are defined.
        drive(0, 2'b00, 3'b000, 0, 1);
        drive(0, 2'b00, 3'b000, 0, 1);
        started = 1'b1;

        // Directed cases.
        drive(1, 2'b10, 3'b010, 1, 0);   // hit
        drive(1, 2'b10, 3'b010, 0, 0);   // match on invalid line: miss
        drive(0, 2'b10, 3'b110, 1, 0);   // upper stored bit kills match
        drive(1, 2'b01, 3'b001, 1, 0);   // H
        drive(1, 2'b01, 3'b011, 1, 0);   // M
        drive(1, 2'b11, 3'b011, 1, 0);   // H
        drive(1, 2'b00, 3'b000, 1, 0);   // H
        drive(0, 2'b00, 3'b000, 0, 0);
        drive(0, 2'b00, 3'b000, 0, 0);
        drive(1, 2'b10, 3'b010, 1, 1);   // reset beats a hit
        drive(0, 2'b10, 3'b010, 1, 0);
        drive(1, 2'b11, 3'b011, 1, 0);   // first post-reset comparison
        drive(0, 2'b00, 3'b000, 0, 0);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] rt;
            logic [2:0] st;
            rt = 2'($urandom_range(3));
            st = ($urandom_range(1) == 1) ? {1'b0, rt} : 3'($urandom_range(7));
            drive(1'($urandom_range(3) != 0), rt, st, 1'($urandom_range(3) != 0),
                  $urandom_range(31) == 0);
        end

        // Saturation: clear, then 65535 hits plus one more, then misses.
        drive(0, 2'b00, 3'b000, 0, 1);
        quiet = 1'b1;
        for (int i = 0; i < 65535; i++) drive(1, 2'b01, 3'b001, 1, 0);
        quiet = 1'b0;
        drive(1, 2'b01, 3'b001, 1, 0);   // at FFFF: stays FFFF
        drive(1, 2'b01, 3'b101, 1, 0);   // miss still counts
        drive(1, 2'b10, 3'b010, 1, 0);
        drive(0, 2'b00, 3'b000, 0, 0);
        drive(0, 2'b00, 3'b000, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
